// File: rtl/raptor64_dcache_fill_pkg.sv
// Shared Raptor64 constants: WISHBONE cycle-type codes and dcache address geometry.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package raptor64_dcache_fill_pkg;

  // WISHBONE registered-feedback cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // dcache geometry: data RAM word index is adr[14:3], tag is adr[63:15]
  localparam int IDX_LO = 3;
  localparam int IDX_HI = 14;
  localparam int IDX_W  = IDX_HI - IDX_LO + 1;
  localparam int TAG_LO = 15;
  localparam int TAG_W  = 64 - TAG_LO;

  localparam logic [7:0] SEL_ALL = 8'hFF;

  // Width of the bus timeout counter (TMO is limited to 1..255)
  localparam int TMO_W = 8;

  // Cycle type for a beat of an incrementing burst
  function automatic logic [2:0] beat_cti(input logic last);
    return last ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/raptor64_bus_timeout.sv
// Bus timeout: loadable down-counter, reloaded on load/clr, flags the last allowed wait cycle.
// Latency: expired is combinational from the count; count updates one cycle after en.
// Backpressure: none; the owner decides what an expiry means.
//
// Ports: clk_i/rst_ni clock and async active-low reset; load and clr both reload TMO
// (clr is intended for a bus ack); en counts one wait cycle; expired is high when the
// current wait cycle is the TMO-th one.
module raptor64_bus_timeout
  import raptor64_dcache_fill_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] TMO_V = TMO_W'(TMO);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load || clr) begin
      cnt <= TMO_V;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Count of 1 means this is the last wait cycle the bus is granted
  assign expired = (cnt == TMO_W'(1));

endmodule

// File: rtl/raptor64_dcache_fill.sv
// Dcache line fill: one WISHBONE incrementing burst per miss, each word written to the data RAM, then the tag.
// Latency: N+2 cycles from acceptance to done_o with zero-wait acks (INV, N beats, DONE); RAM write 1 cycle after ack.
// Backpressure: bus wait states simply stretch FILL; req_i is only sampled in IDLE; bus timeout after TMO idle cycles.
//
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/req_adr_i miss request
// (level, held until done_o/err_o); busy_o/done_o/err_o status; cyc_o..adr_o, ack_i,
// err_i, dat_i WISHBONE read master; cwr_o/csel_o/cadr_o/cdat_o data RAM write port;
// tag_wr_o/tag_adr_o/tag_o/tag_v_o tag RAM write port.
module raptor64_dcache_fill
  import raptor64_dcache_fill_pkg::*;
#(
  parameter int          LW  = 2,
  parameter int unsigned TMO = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [63:0]          req_adr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic [2:0]           cti_o,
  output logic [1:0]           bte_o,
  output logic                 we_o,
  output logic [7:0]           sel_o,
  output logic [63:0]          adr_o,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic [63:0]          dat_i,
  output logic                 cwr_o,
  output logic [7:0]           csel_o,
  output logic [IDX_W-1:0]     cadr_o,
  output logic [63:0]          cdat_o,
  output logic                 tag_wr_o,
  output logic [IDX_W-LW-1:0]  tag_adr_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 tag_v_o
);

  typedef enum logic [2:0] {S_IDLE, S_INV, S_FILL, S_DONE, S_ERR} state_t;

  // Byte offset within a line; only these bits move during a burst
  localparam logic [63:0] OFF_MASK = (64'd1 << (LW + 3)) - 64'd1;
  localparam logic [LW:0] LAST     = (LW + 1)'((1 << LW) - 1);

  state_t      state;
  logic [63:0] base;
  logic [LW:0] wcnt;
  logic [LW:0] wcnt_nxt;
  logic [63:0] adr_inc;
  logic [63:0] adr_nxt;
  logic        tmo_en;
  logic        tmo_exp;
  logic        timeout;

  assign bte_o = 2'b00;
  assign we_o  = 1'b0;

  assign wcnt_nxt = wcnt + 1'b1;
  assign adr_inc  = adr_o + 64'd8;
  assign adr_nxt  = (adr_inc & OFF_MASK) | (adr_o & ~OFF_MASK);

  // A cycle counts toward the timeout only while the strobe waits unanswered
  assign tmo_en  = (state == S_FILL) && !ack_i && !err_i;
  assign timeout = tmo_en && tmo_exp;

  raptor64_bus_timeout #(
    .TMO (TMO)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (state != S_FILL),
    .clr     ((state == S_FILL) && ack_i),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  // All outputs are registered: each is assigned here with the value it shows in the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      base      <= '0;
      wcnt      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      cti_o     <= CTI_CLASSIC;
      sel_o     <= '0;
      adr_o     <= '0;
      cwr_o     <= 1'b0;
      csel_o    <= '0;
      cadr_o    <= '0;
      cdat_o    <= '0;
      tag_wr_o  <= 1'b0;
      tag_adr_o <= '0;
      tag_o     <= '0;
      tag_v_o   <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      cwr_o    <= 1'b0;
      csel_o   <= '0;
      tag_wr_o <= 1'b0;
      tag_v_o  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_i) begin
            base      <= req_adr_i & ~OFF_MASK;
            wcnt      <= '0;
            tag_adr_o <= req_adr_i[IDX_HI:IDX_LO+LW];
            tag_o     <= req_adr_i[63:TAG_LO];
            // Invalidate first so the old tag never hits half-overwritten data
            tag_wr_o  <= 1'b1;
            busy_o    <= 1'b1;
            state     <= S_INV;
          end
        end

        S_INV: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          sel_o <= SEL_ALL;
          adr_o <= base;
          cti_o <= beat_cti(LAST == '0);
          state <= S_FILL;
        end

        S_FILL: begin
          if (err_i || timeout) begin
            // err_i beats ack_i: that beat's data is dropped
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            sel_o <= '0;
            cti_o <= CTI_CLASSIC;
            err_o <= 1'b1;
            state <= S_ERR;
          end else if (ack_i) begin
            cwr_o  <= 1'b1;
            csel_o <= SEL_ALL;
            cadr_o <= adr_o[IDX_HI:IDX_LO];
            cdat_o <= dat_i;
            wcnt   <= wcnt_nxt;
            adr_o  <= adr_nxt;
            if (wcnt == LAST) begin
              cyc_o    <= 1'b0;
              stb_o    <= 1'b0;
              sel_o    <= '0;
              cti_o    <= CTI_CLASSIC;
              tag_wr_o <= 1'b1;
              tag_v_o  <= 1'b1;
              tag_o    <= base[63:TAG_LO];
              done_o   <= 1'b1;
              state    <= S_DONE;
            end else begin
              cti_o <= beat_cti(wcnt_nxt == LAST);
            end
          end
        end

        S_DONE, S_ERR: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raptor64_dcache_fill.sv
// Scoreboard bench for the dcache line fill: directed requests push expected bus beats,
// RAM writes, tag writes and completions; an independent monitor pops and compares.
module tb_raptor64_dcache_fill;

  localparam int LW  = 2;
  localparam int TMO = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic [63:0]       req_adr_i = '0;
  logic              busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [2:0]        cti_o;
  logic [1:0]        bte_o;
  logic [7:0]        sel_o, csel_o;
  logic [63:0]       adr_o, cdat_o;
  logic              ack_i = 1'b0;
  logic              err_i = 1'b0;
  logic [63:0]       dat_i = '0;
  logic              cwr_o, tag_wr_o, tag_v_o;
  logic [11:0]       cadr_o;
  logic [9:0]        tag_adr_o;
  logic [48:0]       tag_o;

  raptor64_dcache_fill #(.LW(LW), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_adr_i(req_adr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o), .bte_o(bte_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .cwr_o(cwr_o), .csel_o(csel_o), .cadr_o(cadr_o), .cdat_o(cdat_o),
    .tag_wr_o(tag_wr_o), .tag_adr_o(tag_adr_o), .tag_o(tag_o), .tag_v_o(tag_v_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  initial forever begin
    @(posedge clk_i);
    cyc_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, want, cyc_cnt);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed { logic [63:0] adr; logic [2:0] cti; } bus_e_t;
  typedef struct packed { logic [11:0] cadr; logic [63:0] dat; } cwr_e_t;
  typedef struct packed { logic [9:0] idx; logic [48:0] tag; logic v; } tag_e_t;

  bus_e_t     exp_bus[$];
  cwr_e_t     exp_cwr[$];
  tag_e_t     exp_tag[$];
  logic [1:0] exp_end[$];   // {done, err}

  task automatic push_fill(input logic [63:0] base, input logic [11:0] cadr0,
                           input logic [9:0] idx, input logic [48:0] tag,
                           input int n_bus, input int n_wr, input bit ok);
    exp_tag.push_back('{idx: idx, tag: tag, v: 1'b0});
    for (int i = 0; i < n_bus; i++)
      exp_bus.push_back('{adr: base + 64'(8 * i), cti: (i == 3) ? 3'b111 : 3'b010});
    for (int i = 0; i < n_wr; i++)
      exp_cwr.push_back('{cadr: cadr0 + 12'(i), dat: 64'(100 + i)});
    if (ok) exp_tag.push_back('{idx: idx, tag: tag, v: 1'b1});
    exp_end.push_back(ok ? 2'b10 : 2'b01);
  endtask

  task automatic drain_check(input string nm);
    chk({nm, "_bus_left"}, 128'(exp_bus.size()), 128'd0);
    chk({nm, "_cwr_left"}, 128'(exp_cwr.size()), 128'd0);
    chk({nm, "_tag_left"}, 128'(exp_tag.size()), 128'd0);
    chk({nm, "_end_left"}, 128'(exp_end.size()), 128'd0);
  endtask

  task automatic flush();
    exp_bus.delete();
    exp_cwr.delete();
    exp_tag.delete();
    exp_end.delete();
  endtask

  // ---------------- bus slave ----------------
  int wait_n   = 0;
  int err_beat = -1;
  bit no_ack   = 1'b0;
  int s_beat   = 0;
  int s_wc     = 0;

  initial forever begin
    @(negedge clk_i);
    if (ack_i || err_i) begin
      s_beat++;
      s_wc = 0;
    end
    ack_i = 1'b0;
    err_i = 1'b0;
    if (!rst_ni || !cyc_o) begin
      s_beat = 0;
      s_wc   = 0;
    end else if (stb_o && !no_ack) begin
      if (s_wc < wait_n) begin
        s_wc++;
      end else begin
        ack_i = 1'b1;
        err_i = (s_beat == err_beat);
        dat_i = 64'(s_beat + 100);
      end
    end
  end

  // ---------------- monitor ----------------
  int     acks_seen = 0;
  bus_e_t mb;
  cwr_e_t mc;
  tag_e_t mt;
  logic [1:0] me;

  initial forever begin
    @(negedge clk_i);
    #1;
    if (rst_ni) begin
      if (stb_o) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", 128'(exp_bus.size()), 128'd1);
        else begin
          mb = exp_bus[0];
          chk("bus_adr", 128'(adr_o), 128'(mb.adr));
          chk("bus_cti", 128'(cti_o), 128'(mb.cti));
          chk("bus_ctl", 128'({cyc_o, we_o, sel_o, bte_o}), 128'(12'b1_0_11111111_00));
          if (ack_i || err_i) void'(exp_bus.pop_front());
          if (ack_i && !err_i) acks_seen++;
        end
      end
      if (cwr_o) begin
        if (exp_cwr.size() == 0) chk("cwr_unexpected", 128'(exp_cwr.size()), 128'd1);
        else begin
          mc = exp_cwr.pop_front();
          chk("cwr_adr", 128'(cadr_o), 128'(mc.cadr));
          chk("cwr_dat", 128'(cdat_o), 128'(mc.dat));
          chk("cwr_sel", 128'(csel_o), 128'(8'hFF));
        end
      end
      if (tag_wr_o) begin
        if (exp_tag.size() == 0) chk("tag_unexpected", 128'(exp_tag.size()), 128'd1);
        else begin
          mt = exp_tag.pop_front();
          chk("tag_wr", 128'({tag_adr_o, tag_o, tag_v_o}), 128'({mt.idx, mt.tag, mt.v}));
        end
      end
      if (done_o || err_o) begin
        if (exp_end.size() == 0) chk("end_unexpected", 128'(exp_end.size()), 128'd1);
        else begin
          me = exp_end.pop_front();
          chk("end_kind", 128'({done_o, err_o}), 128'(me));
        end
      end
    end
  end

  // ---------------- request driver ----------------
  // Called at a negedge: raises req_i now, returns at the negedge of the done/err cycle.
  task automatic run_req(input logic [63:0] a, output int t_inv, output int t_stb,
                         output int t_end);
    t_inv = -1; t_stb = -1; t_end = -1;
    req_i = 1'b1;
    req_adr_i = a;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (busy_o) break;
    end
    chk("accept_busy", 128'(busy_o), 128'd1);
    t_inv = cyc_cnt;
    for (int k = 0; k < 400; k++) begin
      if (stb_o && t_stb < 0) t_stb = cyc_cnt;
      if (done_o || err_o) break;
      @(negedge clk_i);
    end
    req_i = 1'b0;
    chk("finish_seen", 128'(done_o | err_o), 128'd1);
    t_end = cyc_cnt;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_adr"}, 128'(adr_o), 128'd0);
    chk({nm, "_cdat"}, 128'(cdat_o), 128'd0);
    chk({nm, "_misc"}, 128'({busy_o, done_o, err_o, cyc_o, stb_o, cti_o, bte_o, we_o, sel_o,
                             cwr_o, csel_o, cadr_o, tag_wr_o, tag_adr_o, tag_o, tag_v_o}), 128'd0);
  endtask

  int ti, ts, te, d, a0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Zero-wait fill
    push_fill(64'h12340, 12'h468, 10'h11A, 49'h2, 4, 4, 1'b1);
    run_req(64'h0000_0000_0001_2348, ti, ts, te);
    chk("zw_latency", 128'(te - (ti - 1)), 128'd6);
    chk("zw_stb_start", 128'(ts - ti), 128'd1);
    @(negedge clk_i);
    drain_check("zw");

    // Three wait states before every ack
    wait_n = 3;
    push_fill(64'h1000, 12'h200, 10'h080, 49'h0, 4, 4, 1'b1);
    run_req(64'h0000_0000_0000_1008, ti, ts, te);
    chk("ws_latency", 128'(te - (ti - 1)), 128'd18);
    wait_n = 0;
    @(negedge clk_i);
    drain_check("ws");

    // Bus error on the third beat, together with ack
    err_beat = 2;
    push_fill(64'h20040, 12'h008, 10'h002, 49'h4, 3, 2, 1'b0);
    run_req(64'h0000_0000_0002_0058, ti, ts, te);
    chk("be_cyc_low", 128'(cyc_o), 128'd0);
    @(negedge clk_i);
    chk("be_idle", 128'(busy_o), 128'd0);
    err_beat = -1;
    drain_check("be");

    // Timeout: no response at all
    no_ack = 1'b1;
    push_fill(64'h3000_0000, 12'h000, 10'h000, 49'h6000, 1, 0, 1'b0);
    run_req(64'h0000_0000_3000_0010, ti, ts, te);
    chk("to_delay", 128'(te - ts), 128'd8);
    chk("to_cyc_low", 128'(cyc_o), 128'd0);
    @(negedge clk_i);
    chk("to_idle", 128'(busy_o), 128'd0);
    no_ack = 1'b0;
    chk("to_bus_left", 128'(exp_bus.size()), 128'd1);
    flush();

    // Asynchronous reset after the second ack
    push_fill(64'h12340, 12'h468, 10'h11A, 49'h2, 4, 4, 1'b1);
    a0 = acks_seen;
    req_adr_i = 64'h0000_0000_0001_2348;
    req_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      #2;
      if (acks_seen - a0 >= 2) break;
    end
    chk("rs_two_acks", 128'(acks_seen - a0), 128'd2);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rs_async");
    req_i = 1'b0;
    flush();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    push_fill(64'hFFFF_FFFF_FFFF_8FE0, 12'h1FC, 10'h07F, 49'h1_FFFF_FFFF_FFFF, 4, 4, 1'b1);
    run_req(64'hFFFF_FFFF_FFFF_8FF8, ti, ts, te);
    chk("rs_new_latency", 128'(te - (ti - 1)), 128'd6);
    @(negedge clk_i);
    drain_check("rs");

    // Back-to-back fills
    push_fill(64'h100, 12'h020, 10'h008, 49'h0, 4, 4, 1'b1);
    push_fill(64'h120, 12'h024, 10'h009, 49'h0, 4, 4, 1'b1);
    run_req(64'h0000_0000_0000_0100, ti, ts, te);
    d = te;
    @(negedge clk_i);
    chk("bb_gap_idle", 128'(busy_o), 128'd0);
    run_req(64'h0000_0000_0000_0120, ti, ts, te);
    chk("bb_inv_cycle", 128'(ti - d), 128'd2);
    chk("bb_latency", 128'(te - (ti - 1)), 128'd6);
    @(negedge clk_i);
    drain_check("bb");

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1);
  end

endmodule

// File: doc/raptor64_dcache_fill.md
Name: raptor64_dcache_fill

Overview:
- Line-fill engine for the Raptor64 data cache.
- On a miss request it runs a WISHBONE incrementing-burst read for one cache line.
- It writes each returned 64-bit word into the data cache RAM write port with all byte lanes selected, then writes the line tag.
- It sits between the CPU miss logic, the system bus, and the dcache data/tag RAMs. It is the writer that feeds the RAM the CPU reads from.

Parameters:
- LW, 2: log2 of words per line (line = 8 << LW bytes; default 4 words, 32 bytes).
- TMO, 255: cycles without ack/err while stb_o is high before a bus timeout is declared (1..255).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  miss request, level; held by requester until done_o or err_o.
- req_adr_i  in  64  miss byte address; sampled only on acceptance.
- busy_o  out  1  fill in progress.
- done_o  out  1  one-cycle pulse: line filled, tag valid.
- err_o  out  1  one-cycle pulse: bus error or timeout, line left invalid.
- cyc_o  out  1  WISHBONE cycle.
- stb_o  out  1  WISHBONE strobe.
- cti_o  out  3  cycle type: 3'b010 during burst, 3'b111 on last beat, 3'b000 idle.
- bte_o  out  2  always 2'b00 (linear).
- we_o  out  1  always 0.
- sel_o  out  8  8'hFF while cyc_o, else 0.
- adr_o  out  64  beat address, 8-byte aligned.
- ack_i  in  1  WISHBONE ack.
- err_i  in  1  WISHBONE error.
- dat_i  in  64  WISHBONE read data.
- cwr_o  out  1  data RAM write strobe.
- csel_o  out  8  data RAM byte selects (8'hFF when cwr_o).
- cadr_o  out  12  data RAM word address [14:3].
- cdat_o  out  64  data RAM write data.
- tag_wr_o  out  1  tag RAM write strobe.
- tag_adr_o  out  12-LW  tag RAM line index (adr[14:3+LW]).
- tag_o  out  49  tag value adr[63:15].
- tag_v_o  out  1  valid bit written with tag.

Behaviour:
- Reset (rst_ni low, async): state IDLE. All outputs 0, including adr_o, cadr_o, cdat_o, tag_o and counters. Any bus cycle in flight is abandoned immediately (cyc_o drops without waiting for ack).
- States: IDLE, INV, FILL, DONE, ERR.
- IDLE: busy_o=0. If req_i is high, latch line base = {req_adr_i[63:3+LW], 0}, clear the word counter and timeout counter, and go to INV.
- INV (1 cycle):
  - Assert tag_wr_o with tag_v_o=0 at the line index, so stale data under the old tag is never hit while words are overwritten.
  - Assert cyc_o/stb_o with adr_o=base and cti_o=010 (111 if LW=0). Go to FILL.
- FILL:
  - Hold cyc_o/stb_o until ack_i, err_i, or timeout.
  - On ack_i: register dat_i and the current word address. Next cycle drive cwr_o=1, csel_o=FF, cadr_o=adr[14:3], cdat_o=data (1-cycle write latency).
  - On ack_i: increment the word counter, advance adr_o by 8 with wrap inside the line (low LW+3 bits only), and clear the timeout counter.
  - cti_o=111 when the counter equals the last word.
  - Ack on the last word: go to DONE.
- DONE (1 cycle):
  - cyc_o/stb_o=0 and cti_o=000.
  - cwr_o for the final word.
  - tag_wr_o=1, tag_v_o=1, tag_o=base[63:15].
  - done_o=1, then IDLE.
- ERR (1 cycle): cyc_o/stb_o=0, err_o=1, no tag write (line stays invalid), then IDLE.
- FILL exits to ERR on err_i, or when the timeout counter reaches TMO with no ack.
- A pending data-RAM write from the preceding ack is still issued in the ERR cycle.
- Simultaneous ack_i and err_i: err_i wins, and that beat's data is not written.
- Wait states: any number of idle cycles between acks is legal; adr_o/cti_o are stable while stb_o is high and ack_i is low.
- req_i is ignored outside IDLE. The requester drops req_i in the cycle it sees done_o/err_o, since IDLE re-samples req_i from the following cycle.
- Back-to-back fills: minimum 1 IDLE cycle between DONE and the next INV.
- busy_o=1 in INV, FILL, DONE, ERR.
- Total latency with zero-wait ack: INV + N beats + DONE = N+2 cycles from acceptance to done_o.

Decomposition:
- Shared raptor64 package: WISHBONE CTI constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111), and the dcache geometry constants (index bits [14:3], tag bits [63:15]).
- FSM state encoding is local.
- One natural sub-module: raptor64_bus_timeout, a loadable down-counter with a clear-on-ack input and an expired output, reusable by the icache fill.

Test Plan:
- Zero-wait fill: req_adr_i=64'h0000_0000_0001_2348, ack every cycle, dat_i=beat index+100. Required response:
  - adr_o sequence 12340, 12348, 12350, 12358 with cti_o 010, 010, 010, 111.
  - cwr_o at cadr_o 12'h468..12'h46B, each 1 cycle after its ack.
  - tag_wr_o v=0 in INV and v=1 in DONE with tag_o=49'h2, tag_adr_o=10'h11A.
  - done_o 6 cycles after acceptance.
- Wait states: 3 idle cycles before each ack. Required: adr_o/cti_o held stable while waiting, exactly 4 cwr_o pulses, done_o once.
- Bus error on beat 2: err_i with ack_i on the third beat. Required:
  - cyc_o low the next cycle and err_o pulses.
  - Only 2 cwr_o pulses.
  - No tag_wr_o with v=1.
  - IDLE after that.
- Timeout: TMO=8, ack_i never asserted. Required: err_o exactly 8 cycles after stb_o rises, cyc_o low, busy_o low the following cycle.
- Reset mid-fill: drive rst_ni low after the 2nd ack. Required: all outputs 0 asynchronously (same cycle), and a new req after release starts at INV with a fresh base.
- Back-to-back: req_i re-asserted the cycle after done_o. Required: exactly one IDLE cycle, then INV for the new line.
